// File: rtl/serial_slave_port.sv
// serial_slave_port: responder end of the serial bus. Receives a header and
// optional write words bit-serially, performs single/burst memory accesses
// and returns read words serially, LSB first.
//
// Ports:
//   clock, rst          rising-edge clock, synchronous active-high reset
//   slave_sel           arbiter grant; dropping it mid-frame aborts
//   m_valid, m_data     master bit strobe and serial bit
//   s_ready             header ack (write) and per-word write ack
//   s_valid, s_data     read data strobe and serial bit
//   s_busy              high whenever not idle
//   mem_addr/wdata/we   local memory request
//   mem_rdata           registered RAM data, valid one cycle after mem_addr
module serial_slave_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  slave_sel,
    input  logic                  m_valid,
    input  logic                  m_data,
    output logic                  s_ready,
    output logic                  s_valid,
    output logic                  s_data,
    output logic                  s_busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int HW   = ADDR_WIDTH + 2;
    localparam int MAXB = (HW > DATA_WIDTH) ? HW : DATA_WIDTH;
    localparam int CW   = $clog2(MAXB + 1);
    localparam int WW   = $clog2(BURST_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_HDR,
        S_ACK,
        S_RX_DATA,
        S_MEM_WR,
        S_MEM_RD,
        S_TX_DATA,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [HW-2:0]         r_hdr;
    logic [DATA_WIDTH-1:0] r_word;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CW-1:0]         r_bcnt;
    logic [WW-1:0]         r_wcnt;
    logic                  r_burst;

    logic [HW-1:0]         w_hdr_sh;
    logic [DATA_WIDTH-1:0] w_word_sh;
    logic                  w_hdr_last;
    logic                  w_bit_last;
    logic                  w_word_last;
    logic                  w_abort;
    logic                  w_tx;

    // Header bits arrive LSB first; once complete, bit0 = rw, bit1 = burst.
    assign w_hdr_sh    = {m_data, r_hdr};
    assign w_word_sh   = {m_data, r_word[DATA_WIDTH-1:1]};
    assign w_hdr_last  = (r_bcnt == CW'(HW - 1));
    assign w_bit_last  = (r_bcnt == CW'(DATA_WIDTH - 1));
    assign w_word_last = (r_wcnt == (r_burst ? WW'(BURST_LEN - 1) : '0));
    assign w_abort     = !slave_sel && (r_state != S_IDLE)
                                    && (r_state != S_DONE);
    assign w_tx        = slave_sel && (r_state == S_TX_DATA);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (slave_sel && m_valid) w_next = S_RX_HDR;
            S_RX_HDR:  if (m_valid && w_hdr_last)
                           w_next = w_hdr_sh[0] ? S_MEM_RD : S_ACK;
            S_ACK:     w_next = S_RX_DATA;
            S_RX_DATA: if (m_valid && w_bit_last) w_next = S_MEM_WR;
            S_MEM_WR:  w_next = w_word_last ? S_DONE : S_RX_DATA;
            S_MEM_RD:  w_next = S_TX_DATA;
            S_TX_DATA: if (w_bit_last)
                           w_next = w_word_last ? S_DONE : S_MEM_RD;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    // Strobes are gated by slave_sel so they fall in the same cycle the
    // grant is lost; an unwritten word is then simply dropped.
    always_comb begin
        s_busy    = (r_state != S_IDLE);
        s_ready   = slave_sel && ((r_state == S_ACK) || (r_state == S_MEM_WR));
        mem_we    = slave_sel && (r_state == S_MEM_WR);
        s_valid   = w_tx;
        s_data    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_tx) begin
            // First bit of each word bypasses straight from the RAM output
            // so the data starts two cycles after the header completes.
            s_data = (r_bcnt == '0) ? mem_rdata[0] : r_word[0];
        end
        if ((r_state == S_MEM_WR) || (r_state == S_MEM_RD)) begin
            mem_addr = r_addr;
        end
        if (r_state == S_MEM_WR) begin
            mem_wdata = r_word;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hdr   <= '0;
            r_word  <= '0;
            r_addr  <= '0;
            r_bcnt  <= '0;
            r_wcnt  <= '0;
            r_burst <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (slave_sel && m_valid) begin
                        r_hdr  <= w_hdr_sh[HW-1:1];
                        r_bcnt <= CW'(1);
                    end
                end
                S_RX_HDR: begin
                    if (m_valid) begin
                        r_hdr <= w_hdr_sh[HW-1:1];
                        if (w_hdr_last) begin
                            r_addr  <= w_hdr_sh[HW-1:2];
                            r_burst <= w_hdr_sh[1];
                            r_bcnt  <= '0;
                            r_wcnt  <= '0;
                        end else begin
                            r_bcnt <= r_bcnt + CW'(1);
                        end
                    end
                end
                S_RX_DATA: begin
                    if (m_valid) begin
                        r_word <= w_word_sh;
                        r_bcnt <= w_bit_last ? '0 : r_bcnt + CW'(1);
                    end
                end
                S_MEM_WR: begin
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                    r_wcnt <= r_wcnt + WW'(1);
                end
                S_TX_DATA: begin
                    r_word <= (r_bcnt == '0) ? (mem_rdata >> 1)
                                             : (r_word >> 1);
                    if (w_bit_last) begin
                        r_bcnt <= '0;
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                        r_wcnt <= r_wcnt + WW'(1);
                    end else begin
                        r_bcnt <= r_bcnt + CW'(1);
                    end
                end
                default: ;
            endcase
            if (w_abort) begin
                r_bcnt <= '0;
                r_wcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_serial_slave_port.sv
// tb_serial_slave_port: drives directed and random serial frames into
// serial_slave_port and checks them against a transaction-level model.
module tb_serial_slave_port;

    logic        clock = 1'b0;
    logic        rst;
    logic        slave_sel;
    logic        m_valid;
    logic        m_data;
    logic        s_ready;
    logic        s_valid;
    logic        s_data;
    logic        s_busy;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    logic [7:0]  ram [4096];
    logic [7:0]  ref_mem [4096];
    logic        pre_en;
    logic [11:0] pre_a;
    logic [7:0]  pre_d;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int viol = 0;

    int          rdy_q[$];
    logic [11:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int          sv_cyc[$];
    logic        sv_bit[$];

    serial_slave_port dut (
        .clock     (clock),
        .rst       (rst),
        .slave_sel (slave_sel),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .s_ready   (s_ready),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_busy    (s_busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (pre_en) ram[pre_a] <= pre_d;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always @(negedge clock) begin
        if (s_ready) rdy_q.push_back(cyc);
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
        if (s_valid) begin
            sv_cyc.push_back(cyc);
            sv_bit.push_back(s_data);
        end
        if (s_ready && s_valid) viol++;
        if (mem_we && !s_ready) viol++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            m_valid = 1'b0;
            m_data  = 1'($urandom_range(0, 1));
            tick();
        end
        m_valid = 1'b1;
        m_data  = b;
        tick();
    endtask

    task automatic drive_noise(input bit noise);
        m_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        m_data  = 1'($urandom_range(0, 1));
    endtask

    task automatic run_frame(input string tag, input bit rw, input bit burst,
                             input logic [11:0] addr, input logic [31:0] wd,
                             input int pause_bit, input int pause_len,
                             input int abort_bit, input bit noise);
        int          n;
        int          p;
        int          gap;
        int          exp_rdy[$];
        logic [13:0] hdr;
        logic [31:0] exp_bits;
        logic [31:0] got_bits;
        n = burst ? 4 : 1;
        hdr = {addr, burst, rw};
        rdy_q.delete();
        wa_q.delete();
        wd_q.delete();
        sv_cyc.delete();
        sv_bit.delete();
        viol = 0;
        slave_sel = 1'b1;
        for (int i = 0; i < 14; i++) begin
            gap = (noise && i > 0) ? int'($urandom_range(0, 2)) : 0;
            send_bit(hdr[i], gap);
        end
        m_valid = 1'b0;
        p = cyc;
        if (!rw) begin
            exp_rdy.push_back(p);
            drive_noise(noise);
            tick();
            m_valid = 1'b0;
            for (int k = 0; k < n; k++) begin
                for (int b = 0; b < 8; b++) begin
                    if (b == pause_bit + 1) gap = pause_len;
                    else gap = noise ? int'($urandom_range(0, 1)) : 0;
                    send_bit(wd[8*k+b], gap);
                    if (b == abort_bit) begin
                        m_valid   = 1'b0;
                        slave_sel = 1'b0;
                        tick();
                        check({tag, " abort busy"}, 64'(s_busy), 64'd0);
                        tick();
                        tick();
                        check({tag, " abort writes"}, 64'(wa_q.size()), 64'd0);
                        return;
                    end
                end
                m_valid = 1'b0;
                exp_rdy.push_back(cyc);
                drive_noise(noise);
                tick();
                m_valid = 1'b0;
            end
            check({tag, " done busy"}, 64'(s_busy), 64'd1);
            tick();
            check({tag, " idle busy"}, 64'(s_busy), 64'd0);
            check({tag, " wr count"}, 64'(wa_q.size()), 64'(n));
            for (int k = 0; k < n && k < wa_q.size(); k++) begin
                check({tag, " wr addr"}, 64'(wa_q[k]), 64'(12'(addr + k)));
                check({tag, " wr data"}, 64'(wd_q[k]), 64'(wd[8*k+:8]));
                ref_mem[12'(addr + k)] = wd[8*k+:8];
            end
        end else begin
            for (int t = 0; t < 9 * n; t++) begin
                drive_noise(noise);
                tick();
            end
            m_valid = 1'b0;
            check({tag, " done busy"}, 64'(s_busy), 64'd1);
            tick();
            check({tag, " idle busy"}, 64'(s_busy), 64'd0);
            exp_bits = '0;
            got_bits = '0;
            for (int k = 0; k < n; k++) exp_bits[8*k+:8] = ref_mem[12'(addr + k)];
            for (int i = 0; i < sv_bit.size() && i < 32; i++) got_bits[i] = sv_bit[i];
            check({tag, " rd bits"}, 64'(sv_bit.size()), 64'(8 * n));
            check({tag, " rd data"}, 64'(got_bits), 64'(exp_bits));
            if (sv_cyc.size() > 0) begin
                check({tag, " rd first"}, 64'(sv_cyc[0]), 64'(p + 1));
                check({tag, " rd last"}, 64'(sv_cyc[sv_cyc.size()-1]),
                      64'(p + 9 * n - 1));
            end
        end
        check({tag, " rdy count"}, 64'(rdy_q.size()), 64'(exp_rdy.size()));
        for (int i = 0; i < exp_rdy.size() && i < rdy_q.size(); i++)
            check({tag, " rdy cycle"}, 64'(rdy_q[i]), 64'(exp_rdy[i]));
        check({tag, " overlap"}, 64'(viol), 64'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [13:0] hdr;
        logic        rw;
        logic        burst;
        logic [11:0] addr;
        logic [31:0] wd;
        rst       = 1'b1;
        slave_sel = 1'b0;
        m_valid   = 1'b0;
        m_data    = 1'b0;
        pre_en    = 1'b0;
        pre_a     = '0;
        pre_d     = '0;
        for (int i = 0; i < 32; i++) begin
            pre_a = 12'(12'hFF0 + i);
            pre_d = 8'($urandom);
            ref_mem[pre_a] = pre_d;
            pre_en = 1'b1;
            tick();
        end
        pre_en = 1'b0;
        tick();
        check("reset outs", 64'({s_ready, s_valid, s_data, s_busy, mem_we,
                                 mem_addr, mem_wdata}), 64'd0);
        rst = 1'b0;
        tick();

        run_frame("t1 wr", 1'b0, 1'b0, 12'h00A, 32'h5C, -1, 0, -1, 1'b0);
        run_frame("t2 rd", 1'b1, 1'b0, 12'h00A, 32'h0, -1, 0, -1, 1'b0);
        check("t2 serial", 64'({sv_bit[7], sv_bit[6], sv_bit[5], sv_bit[4],
                                sv_bit[3], sv_bit[2], sv_bit[1], sv_bit[0]}),
              64'h5C);
        run_frame("t3 bwr", 1'b0, 1'b1, 12'hFFE, 32'h44332211, -1, 0, -1, 1'b0);
        check("t3 wrap addr", 64'(wa_q[2]), 64'h000);
        run_frame("t3 brd", 1'b1, 1'b1, 12'hFFE, 32'h0, -1, 0, -1, 1'b0);
        run_frame("t4 pause", 1'b0, 1'b0, 12'h003, 32'hA7, 3, 3, -1, 1'b0);
        run_frame("t5 abort", 1'b0, 1'b0, 12'h005, 32'h3C, -1, 0, 5, 1'b0);
        run_frame("t5 clean", 1'b0, 1'b0, 12'h005, 32'h96, -1, 0, -1, 1'b0);
        run_frame("t5 rdback", 1'b1, 1'b0, 12'h005, 32'h0, -1, 0, -1, 1'b0);

        slave_sel = 1'b1;
        hdr = {12'h00A, 1'b0, 1'b1};
        for (int i = 0; i < 14; i++) send_bit(hdr[i], 0);
        m_valid = 1'b0;
        tick();
        tick();
        tick();
        check("t6 in tx", 64'(s_valid), 64'd1);
        rst = 1'b1;
        tick();
        check("t6 reset outs", 64'({s_ready, s_valid, s_data, s_busy, mem_we,
                                    mem_addr, mem_wdata}), 64'd0);
        rst = 1'b0;
        slave_sel = 1'b0;
        tick();
        check("t6 idle", 64'(s_busy), 64'd0);

        for (int r = 0; r < 24; r++) begin
            rw    = 1'($urandom_range(0, 1));
            burst = 1'($urandom_range(0, 1));
            addr  = 12'(12'hFF4 + $urandom_range(0, 20));
            wd    = $urandom;
            run_frame($sformatf("rnd%0d", r), rw, burst, addr, wd,
                      int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                      -1, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
